// File: rtl/serial_tx_frame.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, optional
// parity bit, then STOP_BITS stop bits on the idle-high line y. A producer
// hands over a word with a valid/ready handshake; abort cancels a frame in flight.
module serial_tx_frame #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              abort,
    output logic              y,
    output logic              mesgul,
    output logic              frame_done
);

    // The timer must reach the longest single state, the stop period.
    localparam int TW = (STOP_BITS * CLKS_PER_BIT > 2) ? $clog2(STOP_BITS * CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              parity_q, parity_d;
    logic              y_q, y_d;
    logic              mesgul_q, mesgul_d;
    logic              frame_done_q, frame_done_d;

    // Ready depends only on state and abort, never on tx_valid.
    assign tx_ready   = (state_q == S_IDLE) && !abort;
    assign y          = y_q;
    assign mesgul     = mesgul_q;
    assign frame_done = frame_done_q;

    // Next-state, bit timing and registered-output computation.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        idx_d        = idx_q;
        shreg_d      = shreg_q;
        parity_d     = parity_q;

        if (abort && (state_q != S_IDLE)) begin
            // Abort wins over any timer advance this cycle.
            state_d = S_IDLE;
            timer_d = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tx_ready && tx_valid) begin
                        shreg_d  = tx_data;
                        parity_d = (^tx_data) ^ (PARITY_ODD != 0);
                        state_d  = S_START;
                        timer_d  = BIT_LAST;
                        idx_d    = '0;
                    end
                end
                S_START: begin
                    if (timer_q == '0) begin
                        state_d = S_DATA;
                        timer_d = BIT_LAST;
                        idx_d   = '0;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                S_DATA: begin
                    if (timer_q == '0) begin
                        if (idx_q == IDX_LAST) begin
                            idx_d = '0;
                            if (PARITY_EN != 0) begin
                                state_d = S_PARITY;
                                timer_d = BIT_LAST;
                            end else begin
                                state_d = S_STOP;
                                timer_d = STOP_LAST;
                            end
                        end else begin
                            idx_d   = idx_q + IW'(1);
                            shreg_d = shreg_q >> 1;
                            timer_d = BIT_LAST;
                        end
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                S_PARITY: begin
                    if (timer_q == '0) begin
                        state_d = S_STOP;
                        timer_d = STOP_LAST;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                S_STOP: begin
                    if (timer_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    timer_d = '0;
                    idx_d   = '0;
                end
            endcase
        end

        // Outputs are derived from the next state so they register in step with it.
        case (state_d)
            S_START:  y_d = 1'b0;
            S_DATA:   y_d = shreg_d[0];
            S_PARITY: y_d = parity_d;
            default:  y_d = 1'b1;
        endcase
        mesgul_d     = (state_d != S_IDLE);
        frame_done_d = (state_d == S_STOP) && (timer_d == '0);
    end

    // State and output registers; reset forces the line idle immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            idx_q        <= '0;
            shreg_q      <= '0;
            parity_q     <= 1'b0;
            y_q          <= 1'b1;
            mesgul_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            idx_q        <= idx_d;
            shreg_q      <= shreg_d;
            parity_q     <= parity_d;
            y_q          <= y_d;
            mesgul_q     <= mesgul_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_serial_tx_frame.sv
// Bench for serial_tx_frame: three configurations side by side (even parity,
// odd parity, no parity with two stop bits), a frame-position model checked
// every cycle, plus hand-computed line patterns for directed frames.
module tb_serial_tx_frame;

    localparam int CPB = 4;
    localparam int DW  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    logic [2:0][7:0] tx_data_r;
    logic [2:0]      tx_valid_r;
    logic [2:0]      abort_r;
    logic [2:0]      tx_ready_w;
    logic [2:0]      y_w;
    logic [2:0]      mesgul_w;
    logic [2:0]      frame_done_w;

    int n_total = 0;
    int n_pass  = 0;

    serial_tx_frame #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_even (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data_r[0]), .tx_valid(tx_valid_r[0]),
        .tx_ready(tx_ready_w[0]), .abort(abort_r[0]), .y(y_w[0]), .mesgul(mesgul_w[0]),
        .frame_done(frame_done_w[0]));

    serial_tx_frame #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_odd (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data_r[1]), .tx_valid(tx_valid_r[1]),
        .tx_ready(tx_ready_w[1]), .abort(abort_r[1]), .y(y_w[1]), .mesgul(mesgul_w[1]),
        .frame_done(frame_done_w[1]));

    serial_tx_frame #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_nopar (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data_r[2]), .tx_valid(tx_valid_r[2]),
        .tx_ready(tx_ready_w[2]), .abort(abort_r[2]), .y(y_w[2]), .mesgul(mesgul_w[2]),
        .frame_done(frame_done_w[2]));

    // ---------------- model ----------------
    function automatic int pe_of(input int i);
        return (i == 2) ? 0 : 1;
    endfunction
    function automatic int odd_of(input int i);
        return (i == 1) ? 1 : 0;
    endfunction
    function automatic int stops_of(input int i);
        return (i == 2) ? 2 : 1;
    endfunction
    function automatic int len_of(input int i);
        return (1 + DW + pe_of(i) + stops_of(i)) * CPB;
    endfunction

    // Line level at a given cycle offset into a frame.
    function automatic logic line_bit(input int i, input logic [7:0] d, input int pos);
        int slot;
        int ones;
        slot = pos / CPB;
        ones = 0;
        for (int b = 0; b < DW; b++) ones += int'(d[b]);
        if (slot == 0) return 1'b0;
        if (slot <= DW) return d[slot-1];
        if (slot == DW + 1 && pe_of(i) == 1) return 1'((ones + odd_of(i)) % 2);
        return 1'b1;
    endfunction

    logic [2:0] m_busy = '0;
    int         m_pos[3] = '{0, 0, 0};
    logic [7:0] m_data[3] = '{8'h00, 8'h00, 8'h00};

    // Model: a frame is a busy window of len_of(i) cycles started by an accept.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                m_busy[i] <= 1'b0;
                m_pos[i]  <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (m_busy[i]) begin
                    if (abort_r[i] || m_pos[i] == len_of(i) - 1) m_busy[i] <= 1'b0;
                    else m_pos[i] <= m_pos[i] + 1;
                end else if (tx_valid_r[i] && !abort_r[i]) begin
                    m_busy[i] <= 1'b1;
                    m_pos[i]  <= 0;
                    m_data[i] <= tx_data_r[i];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Cycle-by-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic exp_y;
            exp_y = m_busy[i] ? line_bit(i, m_data[i], m_pos[i]) : 1'b1;
            chk($sformatf("y[%0d]", i), 32'(y_w[i]), 32'(exp_y));
            chk($sformatf("mesgul[%0d]", i), 32'(mesgul_w[i]), 32'(m_busy[i]));
            chk($sformatf("frame_done[%0d]", i), 32'(frame_done_w[i]),
                32'(m_busy[i] && m_pos[i] == len_of(i) - 1));
            chk($sformatf("tx_ready[%0d]", i), 32'(tx_ready_w[i]), 32'(!m_busy[i] && !abort_r[i]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_frame(input int i, input logic [7:0] d);
        @(posedge clk); #1;
        tx_data_r[i]  = d;
        tx_valid_r[i] = 1'b1;
        @(posedge clk); #1;
        tx_valid_r[i] = 1'b0;
        tx_data_r[i]  = ~d;
    endtask

    // Samples mid-bit line levels until frame_done; returns slot pattern and length.
    task automatic capture(input int i, output logic [15:0] slots, output int cycles,
                           output logic ready_seen, output logic idle_seen);
        logic done;
        slots = '0; cycles = 0; ready_seen = 1'b0; idle_seen = 1'b0; done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (tx_ready_w[i]) ready_seen = 1'b1;
            if (!mesgul_w[i]) idle_seen = 1'b1;
            if (cycles % CPB == 2 && cycles / CPB < 16) slots[cycles / CPB] = y_w[i];
            cycles++;
            if (frame_done_w[i]) done = 1'b1;
        end
        if (!done) chk("frame_done_timeout", 32'd0, 32'd1);
    endtask

    logic [15:0] slots;
    int          cycles;
    logic        ready_seen, idle_seen, fd_seen;

    initial begin
        reset_n    = 1'b0;
        tx_data_r  = '0;
        tx_valid_r = '0;
        abort_r    = '0;

        @(negedge clk);
        chk("reset_y", 32'(y_w), 32'h7);
        chk("reset_mesgul", 32'(mesgul_w), 32'h0);
        chk("reset_frame_done", 32'(frame_done_w), 32'h0);
        #7 reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_ready", 32'(tx_ready_w), 32'h7);

        // T1: 0xA5, even parity, one stop bit.
        start_frame(0, 8'hA5);
        capture(0, slots, cycles, ready_seen, idle_seen);
        chk("T1_bits", 32'(slots[10:0]), 32'(11'b10101001010));
        chk("T1_len", cycles, 44);
        chk("T1_ready_low", 32'(ready_seen), 32'd0);

        // T2: odd parity.
        start_frame(1, 8'h01);
        capture(1, slots, cycles, ready_seen, idle_seen);
        chk("T2_par_01", 32'(slots[9]), 32'd0);
        chk("T2_bits_01", 32'(slots[10:0]), 32'(11'b10000000010));
        start_frame(1, 8'h00);
        capture(1, slots, cycles, ready_seen, idle_seen);
        chk("T2_par_00", 32'(slots[9]), 32'd1);
        chk("T2_bits_00", 32'(slots[10:0]), 32'(11'b11000000000));

        // T3: no parity, two stop bits.
        start_frame(2, 8'hFF);
        capture(2, slots, cycles, ready_seen, idle_seen);
        chk("T3_bits", 32'(slots[10:0]), 32'(11'b11111111110));
        chk("T3_len", cycles, 44);
        chk("T3_ready_low", 32'(ready_seen), 32'd0);
        chk("T3_busy_all", 32'(idle_seen), 32'd0);

        // T4: valid held high across two words, one idle cycle between frames.
        @(posedge clk); #1;
        tx_data_r[0]  = 8'h3C;
        tx_valid_r[0] = 1'b1;
        @(posedge clk); #1;
        tx_data_r[0]  = 8'hC3;
        capture(0, slots, cycles, ready_seen, idle_seen);
        chk("T4_frame1_bits", 32'(slots[10:0]), 32'(11'b10001111000));
        chk("T4_frame1_len", cycles, 44);
        @(negedge clk);
        chk("T4_gap_y", 32'(y_w[0]), 32'd1);
        chk("T4_gap_ready", 32'(tx_ready_w[0]), 32'd1);
        chk("T4_gap_mesgul", 32'(mesgul_w[0]), 32'd0);
        @(posedge clk); #1;
        tx_valid_r[0] = 1'b0;
        capture(0, slots, cycles, ready_seen, idle_seen);
        chk("T4_frame2_bits", 32'(slots[10:0]), 32'(11'b10110000110));
        chk("T4_frame2_len", cycles, 44);

        // T5: abort during data bit 3 of 0x55.
        start_frame(0, 8'h55);
        repeat (17) @(posedge clk);
        #1 abort_r[0] = 1'b1;
        @(posedge clk); #1;
        abort_r[0] = 1'b0;
        @(negedge clk);
        chk("T5_abort_y", 32'(y_w[0]), 32'd1);
        chk("T5_abort_mesgul", 32'(mesgul_w[0]), 32'd0);
        fd_seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (frame_done_w[0]) fd_seen = 1'b1;
        end
        chk("T5_no_frame_done", 32'(fd_seen), 32'd0);
        // Abort while idle blocks the accept.
        @(posedge clk); #1;
        abort_r[0]    = 1'b1;
        tx_valid_r[0] = 1'b1;
        tx_data_r[0]  = 8'h99;
        #1 chk("T5_idle_abort_ready", 32'(tx_ready_w[0]), 32'd0);
        @(posedge clk); #1;
        abort_r[0]    = 1'b0;
        tx_valid_r[0] = 1'b0;
        @(negedge clk);
        chk("T5_idle_abort_no_accept", 32'(mesgul_w[0]), 32'd0);
        start_frame(0, 8'h0F);
        capture(0, slots, cycles, ready_seen, idle_seen);
        chk("T5_fresh_bits", 32'(slots[10:0]), 32'(11'b10000011110));
        chk("T5_fresh_len", cycles, 44);

        // T6: asynchronous reset in the middle of the stop period.
        start_frame(2, 8'hA5);
        repeat (38) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("T6_async_y", 32'(y_w[2]), 32'd1);
        chk("T6_async_mesgul", 32'(mesgul_w[2]), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("T6_ready_after", 32'(tx_ready_w), 32'h7);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
